// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed common-anode 7-segment scan driver with
//            frame-aligned pattern snapshot, per-digit enable and blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [7:0]              seg_n,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYCLES);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_pending = 1'b1;

    logic [c_cnt_w-1:0]             r_cnt;
    logic [c_idx_w-1:0]             r_idx;
    logic [NUM_DIGITS-1:0][7:0]     r_shadow_seg;
    logic [NUM_DIGITS-1:0]          r_shadow_en;
    logic [0:0]                     r_state;
    logic                           r_load_ack;
    logic [NUM_DIGITS-1:0]          r_anode_n;
    logic [7:0]                     r_seg_n;
    logic [2:0]                     r_digit_idx;
    logic                           r_frame_done;

    logic                           w_slot_end;
    logic                           w_wrap;
    logic                           w_capture;
    logic                           w_dark;
    logic [NUM_DIGITS-1:0]          w_sel;

    assign w_slot_end = (r_cnt == c_cnt_last);
    assign w_wrap     = w_slot_end && (r_idx == c_idx_last);
    // A request (new or already pending) is only honoured on the frame wrap,
    // so a frame is always drawn from a single snapshot.
    assign w_capture  = w_wrap && (load || (r_state == c_st_pending));
    assign w_dark     = (r_cnt < c_blank) || !r_shadow_en[r_idx];
    assign w_sel      = NUM_DIGITS'(1) << r_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow_seg <= '0;
            r_shadow_en  <= '0;
            r_state      <= c_st_idle;
            r_load_ack   <= 1'b0;
            r_anode_n    <= '1;
            r_seg_n      <= 8'hFF;
            r_digit_idx  <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (load && !w_wrap) begin
                        r_state <= c_st_pending;
                    end
                end
                c_st_pending: begin
                    if (w_wrap) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            if (w_capture) begin
                r_shadow_seg <= seg_in;
                r_shadow_en  <= digit_en;
            end

            r_load_ack   <= w_capture;
            r_frame_done <= w_wrap;
            r_anode_n    <= w_dark ? '1 : ~w_sel;
            r_seg_n      <= ~r_shadow_seg[r_idx];
            r_digit_idx  <= 3'(r_idx);
        end
    end

    assign load_ack   = r_load_ack;
    assign anode_n    = r_anode_n;
    assign seg_n      = r_seg_n;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Self-checking bench: directed vector table plus randomized run
//            against a cycle-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BL = 2;
    localparam int FRAME = ND * PS;

    logic            clk = 1'b0;
    logic            reset;
    logic [8*ND-1:0] seg_in;
    logic [ND-1:0]   digit_en;
    logic            load;
    logic            load_ack;
    logic [ND-1:0]   anode_n;
    logic [7:0]      seg_n;
    logic [2:0]      digit_idx;
    logic            frame_done;

    int checks   = 0;
    int failures = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .digit_en   (digit_en),
        .load       (load),
        .load_ack   (load_ack),
        .anode_n    (anode_n),
        .seg_n      (seg_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: m_n is the number of clock edges since reset; the
    // scan position is plain arithmetic on that count.
    int               m_n     = 0;
    bit               m_valid = 1'b0;
    logic [ND-1:0][7:0] m_seg;
    logic [ND-1:0]    m_en;
    bit               m_req;
    logic [ND-1:0]    e_anode;
    logic [7:0]       e_seg;
    logic [2:0]       e_idx;
    logic             e_ack;
    logic             e_fd;

    always begin
        @(posedge clk);
        if (reset) begin
            m_n = 0; m_seg = '0; m_en = '0; m_req = 1'b0; m_valid = 1'b1;
            e_anode = '1; e_seg = 8'hFF; e_idx = 3'd0; e_ack = 1'b0; e_fd = 1'b0;
        end else if (m_valid) begin
            int pos, dig;
            bit wrap;
            pos     = m_n % PS;
            dig     = (m_n / PS) % ND;
            wrap    = (m_n % FRAME) == FRAME - 1;
            e_anode = (pos < BL || !m_en[dig]) ? 4'hF : ~(4'b0001 << dig);
            e_seg   = ~m_seg[dig];
            e_idx   = 3'(dig);
            e_fd    = wrap;
            e_ack   = wrap && (m_req || load);
            if (e_ack) begin
                m_seg = seg_in; m_en = digit_en; m_req = 1'b0;
            end else if (load) begin
                m_req = 1'b1;
            end
            m_n++;
        end
        #1;
        if (m_valid) begin
            checks++;
            if ({anode_n, seg_n, digit_idx, load_ack, frame_done} !==
                {e_anode, e_seg, e_idx, e_ack, e_fd}) begin
                failures++;
                $display("FAIL model@%0d: got an=%b seg=%h idx=%0d ack=%b fd=%b expected an=%b seg=%h idx=%0d ack=%b fd=%b",
                         m_n, anode_n, seg_n, digit_idx, load_ack, frame_done,
                         e_anode, e_seg, e_idx, e_ack, e_fd);
            end
        end
    end

    typedef struct {
        int              cyc;
        logic            ld;
        logic [8*ND-1:0] seg;
        logic [ND-1:0]   en;
    } stim_t;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [7:0] sg;
        logic [2:0] ix;
        logic       ack;
        logic       fd;
    } vec_t;

    localparam logic [8*ND-1:0] P1 = {8'hF2, 8'hDA, 8'h60, 8'hFC};
    localparam logic [8*ND-1:0] P2 = {8'hB6, 8'h66, 8'hF2, 8'hB6};

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t stim[$];
        vec_t  tbl[$];
        int    si;
        int    ack_cnt, lit_cnt;

        stim.push_back('{70,  1'b1, P1, 4'b1111});
        stim.push_back('{71,  1'b0, P1, 4'b1111});
        stim.push_back('{130, 1'b1, P1, 4'b0101});
        stim.push_back('{131, 1'b0, P1, 4'b0101});
        stim.push_back('{191, 1'b1, P2, 4'b1111});
        stim.push_back('{192, 1'b0, P2, 4'b1111});
        stim.push_back('{200, 1'b1, P2, 4'b1111});
        stim.push_back('{201, 1'b0, P2, 4'b1111});
        stim.push_back('{205, 1'b1, P2, 4'b1111});
        stim.push_back('{206, 1'b0, P2, 4'b1111});
        stim.push_back('{210, 1'b1, P2, 4'b1111});
        stim.push_back('{211, 1'b0, P2, 4'b1111});

        // k = edges since reset; outputs after edge k reflect cycle k-1
        tbl.push_back('{1,   4'hF, 8'hFF, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{9,   4'hF, 8'hFF, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{32,  4'hF, 8'hFF, 3'd3, 1'b0, 1'b1});
        tbl.push_back('{33,  4'hF, 8'hFF, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{64,  4'hF, 8'hFF, 3'd3, 1'b0, 1'b1});
        tbl.push_back('{96,  4'hF, 8'hFF, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{97,  4'hF, 8'h03, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{98,  4'hF, 8'h03, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{99,  4'hE, 8'h03, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{104, 4'hE, 8'h03, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{105, 4'hF, 8'h9F, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{107, 4'hD, 8'h9F, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{115, 4'hB, 8'h25, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{123, 4'h7, 8'h0D, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{128, 4'h7, 8'h0D, 3'd3, 1'b0, 1'b1});
        tbl.push_back('{160, 4'h7, 8'h0D, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{163, 4'hE, 8'h03, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{171, 4'hF, 8'h9F, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{179, 4'hB, 8'h25, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{187, 4'hF, 8'h0D, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{192, 4'hF, 8'h0D, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{195, 4'hE, 8'h49, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{224, 4'h7, 8'h49, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{225, 4'hF, 8'h49, 3'd0, 1'b0, 1'b0});

        reset = 1'b1; load = 1'b0; seg_in = '0; digit_en = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        si = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            while (si < stim.size() && stim[si].cyc < tbl[i].k) begin
                while (m_n < stim[si].cyc) @(negedge clk);
                load = stim[si].ld; seg_in = stim[si].seg; digit_en = stim[si].en;
                si++;
            end
            while (m_n < tbl[i].k) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("tbl[%0d].anode_n", i),   32'(anode_n),    32'(tbl[i].an));
            chk($sformatf("tbl[%0d].seg_n", i),     32'(seg_n),      32'(tbl[i].sg));
            chk($sformatf("tbl[%0d].digit_idx", i), 32'(digit_idx),  32'(tbl[i].ix));
            chk($sformatf("tbl[%0d].load_ack", i),  32'(load_ack),   32'(tbl[i].ack));
            chk($sformatf("tbl[%0d].frame_done", i),32'(frame_done), 32'(tbl[i].fd));
        end

        // Reset while a request is pending: the request must vanish.
        while (m_n < 230) @(negedge clk);
        load = 1'b1; seg_in = P1; digit_en = 4'b1111;
        @(negedge clk);
        load = 1'b0;
        while (m_n < 240) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pending.anode_n", 32'(anode_n), 32'hF);
        chk("reset_pending.seg_n",   32'(seg_n),   32'hFF);
        chk("reset_pending.ack",     32'(load_ack), 32'h0);
        reset = 1'b0;
        ack_cnt = 0; lit_cnt = 0;
        repeat (3 * FRAME) begin
            @(posedge clk);
            #1;
            if (load_ack) ack_cnt++;
            if (anode_n !== 4'hF) lit_cnt++;
        end
        chk("reset_pending.ack_count", 32'(ack_cnt), 32'd0);
        chk("reset_pending.lit_count", 32'(lit_cnt), 32'd0);

        // Randomized traffic, checked every cycle by the model
        @(negedge clk);
        repeat (3000) begin
            load = ($urandom % 8) == 0;
            if (($urandom % 4) == 0) seg_in = $urandom;
            if (($urandom % 16) == 0) digit_en = 4'($urandom);
            reset = ($urandom % 700) == 0;
            @(negedge clk);
        end
        reset = 1'b0; load = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
